offchip_mem_model: RTL and testbench
====================================

Name: offchip_mem_model

Overview:
- Parametrised behavioural model of a slow off-chip memory for the cache test environment; it supersedes the fixed-latency, read-only memory model.
- Supports reads and writes, configurable address/data width, depth and latency.
- Uses a valid/ready request channel, a one-cycle response pulse and an out-of-range error flag.
- Sits below the cache controller's miss/refill and write-back path.

Parameters:
- ADDR_W, 6, request address width in bits.
- DATA_W, 64, data width in bits (one cache line).
- DEPTH, 64, number of implemented words (1..2**ADDR_W); addresses >= DEPTH are out of range.
- LATENCY, 5, cycles from request acceptance to response pulse (>= 1).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, model can accept a request this cycle.
- req_we, input, 1, 1 = write, 0 = read.
- req_addr, input, ADDR_W, word address.
- req_wdata, input, DATA_W, write data.
- rsp_valid, output, 1, one-cycle response pulse (read data or write ack).
- rsp_rdata, output, DATA_W, read data; 0 when rsp_valid=0, on write acks, and on errors.
- rsp_err, output, 1, qualifies rsp_valid: the address was out of range.

Behaviour:
- Storage: array of DEPTH x DATA_W, initialised to all-zero at time zero. Reset does not clear it.
- State machine:
  - IDLE: req_ready=1. An accept (req_valid & req_ready) latches we, addr and wdata into holding registers, loads cnt=1 and moves to WAIT. If LATENCY==1 it moves straight to RESP.
  - WAIT: req_ready=0. cnt increments each cycle; when cnt==LATENCY-1 the next state is RESP.
  - RESP: rsp_valid=1 for exactly this cycle. req_ready=1, so a new accept here loads the holding registers, sets cnt=1 and goes to WAIT (or RESP if LATENCY==1). With no accept, the next state is IDLE.
- Timing: a request accepted at edge T gives rsp_valid high in the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after acceptance. Back-to-back throughput is one request per LATENCY cycles.
- Reads: rsp_rdata = mem[addr_q] during RESP. It reflects any write committed by an earlier response, including one committed at the immediately preceding RESP.
- Writes: mem[addr_q] <= wdata_q at the clock edge that ends the RESP cycle. rsp_rdata=0 on the write ack.
- Out of range (addr_q >= DEPTH): rsp_err=1 with rsp_valid. No array access, writes are discarded, rsp_rdata=0.
- Inputs outside accept cycles are ignored. Holding registers are not updated while in WAIT.
- Counter width: $clog2(LATENCY+1). The counter never wraps.
- Reset values (asynchronous, immediate on rst=1): state=IDLE, cnt=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, holding registers 0, req_ready=0 while rst is high and 1 from the first cycle after release.
- Reset mid-operation: the pending request is dropped, no response is issued, and a pending write is not committed.
- Parameter check: elaboration-time error if LATENCY<1 or DEPTH>2**ADDR_W.

Decomposition:
- Shared package mem_model_pkg:
  - state enum (IDLE/WAIT/RESP, 2 bits);
  - default width and latency constants shared with the cache controller;
  - a function computing the counter width.
- Sub-module mem_latency_ctr: counter plus state machine producing the accept, rsp_fire and busy strobes. The storage array and the holding registers stay in the top module.

Test Plan:
- Read after reset, defaults: reset, then read addr 3 accepted at cycle 10 -> rsp_valid only at cycle 15, rsp_rdata=0, rsp_err=0; req_ready low in cycles 11-14.
- Write then read: write 0xDEADBEEF_CAFEF00D to addr 7, then read addr 7 accepted in the write's RESP cycle -> write ack with rdata=0, then 5 cycles later rdata=0xDEADBEEF_CAFEF00D.
- Out of range: DEPTH=48, read addr 50 -> rsp_valid=1, rsp_err=1, rdata=0; a write to addr 60 followed by a read of addr 60 mod 48=12 shows 12 unchanged.
- LATENCY=1 streaming: req_valid held high on addrs 0,1,2 -> responses on three consecutive cycles, each one cycle after acceptance; req_ready stays 1.
- Reset mid-operation: write addr 5 = 0xAA, rst pulsed 2 cycles after accept -> no rsp_valid. A later read of addr 5 returns 0, and all outputs are 0 during reset.
- Ignored inputs: toggle req_addr, req_we and req_wdata while in WAIT -> response uses the values latched at acceptance; no extra responses.

Source files
------------

// File: rtl/mem_model_pkg.sv
// -----------------------------------------------------------------------------
// mem_model_pkg
// Shared definitions for the off-chip memory model and the cache controller
// that talks to it:
//   - state_e     : request/response state machine encoding (IDLE/WAIT/RESP)
//   - MEM_*       : default address/data width, depth and latency
//   - ctr_width() : width of a counter that must hold the value LATENCY
// -----------------------------------------------------------------------------
package mem_model_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int MEM_ADDR_W  = 6;
   localparam int MEM_DATA_W  = 64;
   localparam int MEM_DEPTH   = 64;
   localparam int MEM_LATENCY = 5;

   // The latency counter counts up to LATENCY, so it needs clog2(LATENCY+1)
   // bits. A nonsensical latency still yields a legal 1-bit width so the
   // parameter check in the top module is what reports the problem.
   function automatic int ctr_width(input int latency);
      return (latency < 1) ? 1 : $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/mem_latency_ctr.sv
// -----------------------------------------------------------------------------
// mem_latency_ctr
// Request/response sequencing for the off-chip memory model. Accepts one
// request at a time, counts LATENCY cycles and fires a one-cycle response
// strobe. A new request may be accepted in the response cycle itself.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   req_valid_i  in   request present
//   req_ready_o  out  a request can be accepted this cycle (0 while in reset)
//   accept_o     out  request handshake completes at the next rising edge
//   rsp_fire_o   out  response cycle (high for exactly one cycle)
//   busy_o       out  waiting out the latency; no request can be accepted
// -----------------------------------------------------------------------------
module mem_latency_ctr
   import mem_model_pkg::*;
#(
   parameter int LATENCY = MEM_LATENCY
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid_i,
   output logic req_ready_o,
   output logic accept_o,
   output logic rsp_fire_o,
   output logic busy_o
);

   localparam int               CNT_W    = ctr_width(LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
   // With a single-cycle latency the response follows the accept directly.
   localparam state_e           ACC_NEXT = (LATENCY == 1) ? RESP : WAIT;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready;
   logic             accept;

   // Ready is forced low while reset is asserted so nothing is handed over
   // to a model that is about to drop it.
   assign ready  = (state_q != WAIT) && !rst;
   assign accept = req_valid_i && ready;

   // NOTE: every variable assigned in always_comb gets a default first;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ACC_NEXT;
               cnt_d   = CNT_ONE;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (accept) begin
               state_d = ACC_NEXT;
               cnt_d   = CNT_ONE;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready_o = ready;
   assign accept_o    = accept;
   assign rsp_fire_o  = (state_q == RESP);
   assign busy_o      = (state_q == WAIT);

endmodule

// File: rtl/offchip_mem_model.sv
// -----------------------------------------------------------------------------
// offchip_mem_model
// Behavioural model of a slow off-chip memory sitting below the cache
// controller's refill and write-back path. One outstanding request at a time;
// the response arrives LATENCY cycles after acceptance as a one-cycle pulse.
// Writes commit at the edge that ends their response cycle. Addresses at or
// beyond DEPTH are flagged with rsp_err and never touch the array.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (array contents survive)
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address [ADDR_W]
//   req_wdata  in   write data [DATA_W]
//   rsp_valid  out  one-cycle response pulse (read data or write ack)
//   rsp_rdata  out  read data; zero outside read responses and on errors
//   rsp_err    out  qualifies rsp_valid: address was out of range
// -----------------------------------------------------------------------------
module offchip_mem_model
   import mem_model_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int DEPTH   = MEM_DEPTH,
   parameter int LATENCY = MEM_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   if (LATENCY < 1 || DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_params
      $error("offchip_mem_model: need LATENCY >= 1 and 1 <= DEPTH <= 2**ADDR_W");
   end

   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic              accept;
   logic              rsp_fire;
   logic              busy;
   logic              load;
   logic              in_range;

   logic              we_q,    we_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   // NOTE: the storage array has no reset; it starts at zero and keeps its
   // contents across rst, like a real external memory.
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

   mem_latency_ctr #(
      .LATENCY     (LATENCY)
   ) u_ctr (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .accept_o    (accept),
      .rsp_fire_o  (rsp_fire),
      .busy_o      (busy)
   );

   // Holding registers only follow the bus on a handshake; anything driven
   // while the model is counting out the latency is ignored.
   assign load = accept && !busy;

   always_comb begin
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (load) begin
         we_d    = req_we;
         addr_d  = req_addr;
         wdata_d = req_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Zero-extend so the compare also works when DEPTH == 2**ADDR_W.
   assign in_range = ({1'b0, addr_q} < DEPTH_L);

   // The write lands at the edge closing the response cycle. An asynchronous
   // reset during that cycle clears rsp_fire first, so the write is dropped.
   always_ff @(posedge clk) begin
      if (rsp_fire && we_q && in_range) begin
         mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
      end
   end

   assign rsp_valid = rsp_fire;
   assign rsp_err   = rsp_fire && !in_range;
   assign rsp_rdata = (rsp_fire && !we_q && in_range) ? mem_q[addr_q[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_offchip_mem_model.sv
// -----------------------------------------------------------------------------
// tb_offchip_mem_model
// Three model instances: defaults (DEPTH 64, LATENCY 5), a short array
// (DEPTH 48) for out-of-range handling, and LATENCY 1 for streaming.
// Stimulus pushes the expected response (cycle, err, data) into a per-instance
// queue; a monitor on the falling edge pops and compares every response.
// -----------------------------------------------------------------------------
module tb_offchip_mem_model;

   localparam int AW = 6;
   localparam int DW = 64;

   typedef struct packed {
      int unsigned   cyc;
      logic          err;
      logic [DW-1:0] rd;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0]    rst;
   logic [2:0]    req_valid;
   logic [2:0]    req_we;
   logic [AW-1:0] req_addr  [3];
   logic [DW-1:0] req_wdata [3];
   wire  [2:0]    req_ready;
   wire  [2:0]    rsp_valid;
   wire  [2:0]    rsp_err;
   wire  [DW-1:0] rsp_rdata [3];

   exp_t sb [3][$];

   int n_checks = 0;
   int n_pass   = 0;

   offchip_mem_model #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(64), .LATENCY(5)) u_dut0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

   offchip_mem_model #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(48), .LATENCY(5)) u_dut1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

   offchip_mem_model #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(64), .LATENCY(1)) u_dut2 (
      .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

   function automatic int lat(input int k);
      return (k == 2) ? 1 : 5;
   endfunction

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
   endtask

   // Present a request, wait (bounded) for the handshake and, if a response
   // is due, record when and what it must be.
   task automatic issue(input int k, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input bit expect_rsp,
                        input logic err, input logic [DW-1:0] rd,
                        output int unsigned acc);
      int n = 0;
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_wdata[k] = wd;
      while (req_ready[k] !== 1'b1 && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("dut%0d accept within bound", k), 96'(n < 64), 96'd1);
      @(posedge clk); #1;
      acc = cyc;
      if (expect_rsp) sb[k].push_back('{cyc: cyc + lat(k) - 1, err: err, rd: rd});
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
   endtask

   task automatic drain(input int k);
      int n = 0;
      while (sb[k].size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check($sformatf("dut%0d all responses seen", k), 96'(sb[k].size()), 96'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input int k, input string tag);
      check($sformatf("dut%0d %s req_ready", k, tag), 96'(req_ready[k]), 96'd0);
      check($sformatf("dut%0d %s rsp_valid", k, tag), 96'(rsp_valid[k]), 96'd0);
      check($sformatf("dut%0d %s rsp_err", k, tag), 96'(rsp_err[k]), 96'd0);
      check($sformatf("dut%0d %s rsp_rdata", k, tag), 96'(rsp_rdata[k]), 96'd0);
   endtask

   // Monitor: every response must be expected, on time and carry the right
   // payload; outside responses the data and error outputs must stay zero.
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (rsp_valid[k] === 1'b1) begin
            if (sb[k].size() == 0) begin
               check($sformatf("dut%0d unexpected response", k), 96'(rsp_valid[k]), 96'd0);
            end else begin
               e = sb[k].pop_front();
               check($sformatf("dut%0d rsp cycle", k), 96'(cyc), 96'(e.cyc));
               check($sformatf("dut%0d rsp_err", k), 96'(rsp_err[k]), 96'(e.err));
               check($sformatf("dut%0d rsp_rdata", k), 96'(rsp_rdata[k]), 96'(e.rd));
            end
         end else begin
            check($sformatf("dut%0d idle err/rdata", k), {31'd0, rsp_err[k], rsp_rdata[k]}, 96'd0);
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1);
   end

   initial begin
      int unsigned a0, a1;
      rst       = '1;
      req_valid = '0;
      req_we    = '0;
      for (int k = 0; k < 3; k++) begin
         req_addr[k]  = '0;
         req_wdata[k] = '0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) check_reset_outputs(k, "in reset");
      rst = '0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++)
         check($sformatf("dut%0d ready after reset", k), 96'(req_ready[k]), 96'd1);

      // Read after reset: zero data, ready low through the four wait cycles
      issue(0, 1'b0, 6'd3, '0, 1'b1, 1'b0, 64'd0, a0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("dut0 ready low in wait %0d", i), 96'(req_ready[0]), 96'd0);
         @(posedge clk); #1;
      end
      check("dut0 ready in response cycle", 96'(req_ready[0]), 96'd1);
      drain(0);

      // Write then read accepted in the write's response cycle
      issue(0, 1'b1, 6'd7, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 64'd0, a0);
      issue(0, 1'b0, 6'd7, '0, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, a1);
      check("dut0 back-to-back accept spacing", 96'(a1 - a0), 96'd5);
      drain(0);

      // Inputs wiggled during the wait must not change or add anything
      issue(0, 1'b0, 6'd7, '0, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, a0);
      for (int i = 0; i < 3; i++) begin
         req_valid[0] = 1'b1;
         req_we[0]    = i[0];
         req_addr[0]  = AW'(20 + i);
         req_wdata[0] = 64'h0BAD_0000_0000_0000 | 64'(i);
         @(posedge clk); #1;
      end
      req_valid[0] = 1'b0;
      req_we[0]    = 1'b0;
      req_addr[0]  = '0;
      req_wdata[0] = '0;
      drain(0);
      issue(0, 1'b0, 6'd7, '0, 1'b1, 1'b0, 64'hDEADBEEF_CAFEF00D, a0);
      drain(0);

      // Reset two cycles after accepting a write: no response, no commit
      issue(0, 1'b1, 6'd5, 64'hAA, 1'b0, 1'b0, 64'd0, a0);
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1'b1;
      #1;
      check_reset_outputs(0, "mid-wait reset");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs(0, "held reset");
      rst[0] = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      // Asynchronous reset inside the response cycle of a write
      issue(0, 1'b1, 6'd6, 64'hBB, 1'b0, 1'b0, 64'd0, a0);
      repeat (4) @(posedge clk);
      #1;
      rst[0] = 1'b1;
      #1;
      check_reset_outputs(0, "resp-cycle reset");
      @(posedge clk); #1;
      rst[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      issue(0, 1'b0, 6'd5, '0, 1'b1, 1'b0, 64'd0, a0);
      issue(0, 1'b0, 6'd6, '0, 1'b1, 1'b0, 64'd0, a0);
      drain(0);

      // Out of range on DEPTH=48
      issue(1, 1'b0, 6'd50, '0, 1'b1, 1'b1, 64'd0, a0);
      issue(1, 1'b1, 6'd12, 64'h55, 1'b1, 1'b0, 64'd0, a0);
      issue(1, 1'b1, 6'd60, 64'h1234, 1'b1, 1'b1, 64'd0, a0);
      issue(1, 1'b0, 6'd12, '0, 1'b1, 1'b0, 64'h55, a0);
      issue(1, 1'b1, 6'd47, 64'h77, 1'b1, 1'b0, 64'd0, a0);
      issue(1, 1'b0, 6'd47, '0, 1'b1, 1'b0, 64'h77, a0);
      issue(1, 1'b0, 6'd48, '0, 1'b1, 1'b1, 64'd0, a0);
      drain(1);

      // LATENCY=1 streaming: six accepts on six consecutive edges
      issue(2, 1'b1, 6'd0, 64'h100, 1'b1, 1'b0, 64'd0, a0);
      check("dut2 ready while streaming 0", 96'(req_ready[2]), 96'd1);
      issue(2, 1'b1, 6'd1, 64'h101, 1'b1, 1'b0, 64'd0, a1);
      check("dut2 ready while streaming 1", 96'(req_ready[2]), 96'd1);
      issue(2, 1'b1, 6'd2, 64'h102, 1'b1, 1'b0, 64'd0, a1);
      issue(2, 1'b0, 6'd0, '0, 1'b1, 1'b0, 64'h100, a1);
      issue(2, 1'b0, 6'd1, '0, 1'b1, 1'b0, 64'h101, a1);
      check("dut2 ready while streaming 4", 96'(req_ready[2]), 96'd1);
      issue(2, 1'b0, 6'd2, '0, 1'b1, 1'b0, 64'h102, a1);
      check("dut2 streaming accept span", 96'(a1 - a0), 96'd5);
      drain(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
